// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - boot loader: UART byte frames into 16-bit instruction-memory writes
module instruction_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [15:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN_HI  = 3'd1;
  localparam logic [2:0] S_LEN_LO  = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  localparam int MAX_WORDS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   WC_ONE   = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  logic [2:0]            state;
  logic [7:0]            len_hi;
  logic [7:0]            data_hi;
  logic [7:0]            chk;
  logic [ADDR_WIDTH:0]   len_words;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           len_full;
  logic [ADDR_WIDTH:0]   wc_next;

  assign len_full = {len_hi, rx_data};
  assign wc_next  = word_count + WC_ONE;
  // busy decodes straight from state so FINISH is the one cycle that still holds it
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len_hi     <= '0;
      data_hi    <= '0;
      chk        <= '0;
      len_words  <= '0;
      addr       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            chk        <= '0;
            addr       <= '0;
            state      <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (rx_valid) begin
            len_hi <= rx_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (rx_valid) begin
            len_words <= (ADDR_WIDTH+1)'(len_full);
            if (int'(len_full) > MAX_WORDS) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= S_IDLE;
            end else if (len_full == 16'd0) begin
              state <= S_CHECK;
            end else begin
              state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (rx_valid) begin
            data_hi <= rx_data;
            chk     <= chk ^ rx_data;
            state   <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (rx_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= addr;
            imem_wdata <= {data_hi, rx_data};
            chk        <= chk ^ rx_data;
            addr       <= addr + ADDR_ONE;
            word_count <= wc_next;
            state      <= (wc_next == len_words) ? S_CHECK : S_DATA_HI;
          end
        end
        S_CHECK: begin
          if (rx_valid) begin
            err   <= (rx_data != chk);
            done  <= 1'b1;
            state <= S_FINISH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - frame-level model and directed vectors for instruction_loader
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [12:0] word_count;

  instruction_loader #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  int          compares = 0;
  int          fails = 0;
  int          cyc = 0;
  int          wr_count = 0;
  wr_t         exp_q[$];
  logic [7:0]  frame[$];
  logic [15:0] mem [0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every cycle: the write strobe must match the model's schedule, and writes land in a shadow memory
  always @(negedge clk) begin
    logic exp_we;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("missed_write_cycle", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    exp_we = (exp_q.size() > 0 && exp_q[0].cyc == cyc);
    chk("imem_we", {31'd0, imem_we}, {31'd0, exp_we});
    if (imem_we && exp_we) begin
      chk("imem_addr", {20'd0, imem_addr}, {20'd0, exp_q[0].addr});
      chk("imem_wdata", {16'd0, imem_wdata}, {16'd0, exp_q[0].data});
      void'(exp_q.pop_front());
    end
    if (imem_we) begin
      mem[imem_addr] = imem_wdata;
      wr_count++;
    end
  end

  task automatic check_reset(input string tag);
    chk($sformatf("%s_imem_we", tag), {31'd0, imem_we}, 0);
    chk($sformatf("%s_imem_addr", tag), {20'd0, imem_addr}, 0);
    chk($sformatf("%s_imem_wdata", tag), {16'd0, imem_wdata}, 0);
    chk($sformatf("%s_busy", tag), {31'd0, busy}, 0);
    chk($sformatf("%s_done", tag), {31'd0, done}, 0);
    chk($sformatf("%s_err", tag), {31'd0, err}, 0);
    chk($sformatf("%s_word_count", tag), {19'd0, word_count}, 0);
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("%s_busy_after_start", tag), {31'd0, busy}, 1);
    chk($sformatf("%s_done_cleared", tag), {31'd0, done}, 0);
  endtask

  // Drives the frame bytes; byte k that is the low byte of word i schedules write i one edge later
  task automatic drive_frame(input bit gap);
    int  n;
    wr_t w;
    n = (frame.size() >= 2) ? int'({frame[0], frame[1]}) : 0;
    for (int k = 0; k < frame.size(); k++) begin
      rx_valid = 1'b1;
      rx_data  = frame[k];
      if (k >= 3 && (k % 2) == 1 && (k - 3) / 2 < n && n <= 4096) begin
        w.cyc  = cyc + 1;
        w.addr = 12'((k - 3) / 2);
        w.data = {frame[k-1], frame[k]};
        exp_q.push_back(w);
      end
      @(negedge clk);
      if (gap && k != frame.size() - 1) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic check_frame_result(input string tag);
    int         n;
    logic [7:0] x;
    logic       exp_err;
    int         exp_wc;
    bit         bad_len;
    n = int'({frame[0], frame[1]});
    bad_len = (n > 4096);
    x = 8'h00;
    if (bad_len) begin
      exp_err = 1'b1;
      exp_wc  = 0;
    end else begin
      for (int i = 0; i < 2 * n; i++) x = x ^ frame[2+i];
      exp_err = (frame[2+2*n] != x);
      exp_wc  = n;
    end
    chk($sformatf("%s_done", tag), {31'd0, done}, 1);
    chk($sformatf("%s_err", tag), {31'd0, err}, {31'd0, exp_err});
    chk($sformatf("%s_word_count", tag), {19'd0, word_count}, exp_wc);
    chk($sformatf("%s_busy_t1", tag), {31'd0, busy}, bad_len ? 0 : 1);
    @(negedge clk);
    chk($sformatf("%s_busy_t2", tag), {31'd0, busy}, 0);
    chk($sformatf("%s_done_held", tag), {31'd0, done}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         wr0;
    logic [7:0] x;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Good load with idle gaps between bytes
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hC0, 8'h05, 8'hE3};
    do_start("good");
    wr0 = wr_count;
    drive_frame(1'b1);
    chk("good_err_lit", {31'd0, err}, 0);
    chk("good_wc_lit", {19'd0, word_count}, 2);
    check_frame_result("good");
    chk("good_mem0", {16'd0, mem[0]}, 32'h1234);
    chk("good_mem1", {16'd0, mem[1]}, 32'hC005);
    chk("good_writes", wr_count - wr0, 2);

    // Empty program
    frame = '{8'h00, 8'h00, 8'h00};
    do_start("empty");
    wr0 = wr_count;
    drive_frame(1'b0);
    chk("empty_err_lit", {31'd0, err}, 0);
    check_frame_result("empty");
    chk("empty_writes", wr_count - wr0, 0);

    // Bad checksum: writes still happen
    mem[0] = 16'h0000; mem[1] = 16'h0000;
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hC0, 8'h05, 8'hFF};
    do_start("badchk");
    wr0 = wr_count;
    drive_frame(1'b0);
    chk("badchk_err_lit", {31'd0, err}, 1);
    check_frame_result("badchk");
    chk("badchk_writes", wr_count - wr0, 2);
    chk("badchk_mem1", {16'd0, mem[1]}, 32'hC005);

    // Bad length 0x1001 > 4096, then a stray byte in IDLE
    frame = '{8'h10, 8'h01};
    do_start("badlen");
    wr0 = wr_count;
    drive_frame(1'b0);
    chk("badlen_busy_lit", {31'd0, busy}, 0);
    check_frame_result("badlen");
    rx_valid = 1'b1; rx_data = 8'h55;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("badlen_stray_busy", {31'd0, busy}, 0);
    chk("badlen_stray_done", {31'd0, done}, 1);
    chk("badlen_writes", wr_count - wr0, 0);

    // Reset mid-load, then reset colliding with start, then a clean load
    frame = '{8'h00, 8'h03, 8'hAB, 8'hCD, 8'h11};
    do_start("midrst");
    wr0 = wr_count;
    drive_frame(1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    chk("midrst_writes", wr_count - wr0, 1);
    chk("midrst_mem0", {16'd0, mem[0]}, 32'hABCD);
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_beats_start_busy", {31'd0, busy}, 0);
    frame = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
    do_start("reload");
    drive_frame(1'b1);
    check_frame_result("reload");
    chk("reload_mem0", {16'd0, mem[0]}, 32'hBEEF);

    // Stress: full 4096-word memory, rx_valid every cycle
    frame = '{8'h10, 8'h00};
    x = 8'h00;
    for (int i = 0; i < 8192; i++) begin
      frame.push_back(8'(i));
      x = x ^ 8'(i);
    end
    frame.push_back(x);
    do_start("stress");
    wr0 = wr_count;
    drive_frame(1'b0);
    chk("stress_err_lit", {31'd0, err}, 0);
    chk("stress_wc_lit", {19'd0, word_count}, 4096);
    check_frame_result("stress");
    repeat (10) @(negedge clk);
    chk("stress_writes", wr_count - wr0, 4096);
    chk("stress_mem0", {16'd0, mem[0]}, 32'h0001);
    chk("stress_mem100", {16'd0, mem[100]}, 32'hC8C9);
    chk("stress_mem4095", {16'd0, mem[4095]}, 32'hFEFF);
    chk("pending_writes", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
